// File: rtl/dual_issue_hazard_ctrl_if.sv
// ID/EX hazard bus between the dual-issue pipeline and its hazard controller.
// The pipeline (master) presents the decoded ID pair and the EX load
// descriptors; the controller (slave) returns stall/flush controls.
// Handshake: there is no valid/ready pair here; the controls are a pure
// function of the current cycle's bus contents and the controller state,
// and the pipeline registers consume them on the next rising clk edge.
interface dual_issue_hazard_ctrl_if;
  logic       valid0_d;
  logic       valid1_d;
  logic [4:0] rs1_d0;
  logic [4:0] rs2_d0;
  logic [4:0] rd_d0;
  logic [4:0] rs1_d1;
  logic [4:0] rs2_d1;
  logic       regwrite_d0;
  logic       mem_d0;
  logic       mem_d1;
  logic       ctl_d0;
  logic       ctl_d1;
  logic       memread_e0;
  logic       memread_e1;
  logic [4:0] rd_e0;
  logic [4:0] rd_e1;
  logic       redirect_e;
  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e0;
  logic       flush_e1;

  modport master (
    output valid0_d, valid1_d, rs1_d0, rs2_d0, rd_d0, rs1_d1, rs2_d1,
           regwrite_d0, mem_d0, mem_d1, ctl_d0, ctl_d1,
           memread_e0, memread_e1, rd_e0, rd_e1, redirect_e,
    input  stall_f, stall_d, flush_d, flush_e0, flush_e1
  );

  modport slave (
    input  valid0_d, valid1_d, rs1_d0, rs2_d0, rd_d0, rs1_d1, rs2_d1,
           regwrite_d0, mem_d0, mem_d1, ctl_d0, ctl_d1,
           memread_e0, memread_e1, rd_e0, rd_e1, redirect_e,
    output stall_f, stall_d, flush_d, flush_e0, flush_e1
  );
endinterface

// File: rtl/dual_issue_hazard_ctrl.sv
// Dual-issue hazard and issue controller: picks dual issue, split issue,
// load-use bubble or redirect flush each cycle and counts those events.
module dual_issue_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dual_issue_hazard_ctrl_if.slave hz,
  output logic                 split_q,
  output logic [CNT_W-1:0]     split_cnt,
  output logic [CNT_W-1:0]     lu_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  typedef enum logic {NORMAL = 1'b0, SPLIT = 1'b1} state_t;

  state_t state_q, state_d;
  logic   inc_split, inc_lu, inc_flush;
  logic   stall_f, stall_d, flush_d, flush_e0, flush_e1;

  // x0 never creates a dependence
  function automatic logic match(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (b != 5'd0);
  endfunction

  // A source register that is the target of a load still in EX
  function automatic logic ld_hit(input logic [4:0] r,
                                  input logic m0, input logic [4:0] d0,
                                  input logic m1, input logic [4:0] d1);
    return (m0 && match(r, d0)) || (m1 && match(r, d1));
  endfunction

  logic hit0, hit1, luse, dep01, conflict;

  // Hazard detection: slot 0 sources are ignored in SPLIT because slot 0 has already issued
  always_comb begin
    hit0 = ld_hit(hz.rs1_d0, hz.memread_e0, hz.rd_e0, hz.memread_e1, hz.rd_e1) ||
           ld_hit(hz.rs2_d0, hz.memread_e0, hz.rd_e0, hz.memread_e1, hz.rd_e1);
    hit1 = ld_hit(hz.rs1_d1, hz.memread_e0, hz.rd_e0, hz.memread_e1, hz.rd_e1) ||
           ld_hit(hz.rs2_d1, hz.memread_e0, hz.rd_e0, hz.memread_e1, hz.rd_e1);
    luse = (hz.valid0_d && (state_q == NORMAL) && hit0) || (hz.valid1_d && hit1);
    dep01 = hz.regwrite_d0 && (match(hz.rs1_d1, hz.rd_d0) || match(hz.rs2_d1, hz.rd_d0));
    conflict = hz.valid0_d && hz.valid1_d &&
               (dep01 || (hz.mem_d0 && hz.mem_d1) || (hz.ctl_d0 && hz.ctl_d1));
  end

  // Issue decision: priority redirect > load-use > pair conflict; all controls held low in reset
  always_comb begin
    state_d   = state_q;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    flush_e0  = 1'b0;
    flush_e1  = 1'b0;
    inc_split = 1'b0;
    inc_lu    = 1'b0;
    inc_flush = 1'b0;
    if (rst_n) begin
      if (hz.redirect_e) begin
        flush_d   = 1'b1;
        flush_e0  = 1'b1;
        flush_e1  = 1'b1;
        inc_flush = 1'b1;
        state_d   = NORMAL;
      end else if (luse) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        flush_e0 = 1'b1;
        flush_e1 = 1'b1;
        inc_lu   = 1'b1;
      end else if (state_q == SPLIT) begin
        // second half of a split: only slot 1 enters EX
        flush_e0 = 1'b1;
        state_d  = NORMAL;
      end else if (conflict) begin
        stall_f   = 1'b1;
        stall_d   = 1'b1;
        flush_e1  = 1'b1;
        inc_split = 1'b1;
        state_d   = SPLIT;
      end
    end
  end

  assign hz.stall_f  = stall_f;
  assign hz.stall_d  = stall_d;
  assign hz.flush_d  = flush_d;
  assign hz.flush_e0 = flush_e0;
  assign hz.flush_e1 = flush_e1;
  assign split_q     = (state_q == SPLIT);

  // State register and saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= NORMAL;
      split_cnt <= '0;
      lu_cnt    <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (inc_split && (split_cnt != '1)) split_cnt <= split_cnt + 1'b1;
      if (inc_lu    && (lu_cnt    != '1)) lu_cnt    <= lu_cnt + 1'b1;
      if (inc_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dual_issue_hazard_ctrl.sv
// Bench for dual_issue_hazard_ctrl: directed scenarios then random traffic,
// checked by a scoreboard fed from a behavioural issue model.
module tb_dual_issue_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int W     = 6 + 3 * CNT_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dual_issue_hazard_ctrl_if hz ();
  logic             split_q;
  logic [CNT_W-1:0] split_cnt, lu_cnt, flush_cnt;

  dual_issue_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hz        (hz.slave),
    .split_q   (split_q),
    .split_cnt (split_cnt),
    .lu_cnt    (lu_cnt),
    .flush_cnt (flush_cnt)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit m_split = 0;
  int m_sc = 0, m_lc = 0, m_fc = 0;

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Predict this cycle's outputs from the issue rules, then advance the model
  task automatic tick();
    logic [4:0] srcs[$];
    bit luse, dep, conflict, ld_dep;
    bit sf, sd, fd, f0, f1;
    int nsc, nlc, nfc;
    bit nsplit;
    sf = 0; sd = 0; fd = 0; f0 = 0; f1 = 0;
    if (!rst_n) begin
      m_split = 0; m_sc = 0; m_lc = 0; m_fc = 0;
      exp_q.push_back('0);
    end else begin
      nsplit = m_split; nsc = m_sc; nlc = m_lc; nfc = m_fc;
      if (hz.valid0_d && !m_split) begin
        srcs.push_back(hz.rs1_d0); srcs.push_back(hz.rs2_d0);
      end
      if (hz.valid1_d) begin
        srcs.push_back(hz.rs1_d1); srcs.push_back(hz.rs2_d1);
      end
      luse = 0;
      foreach (srcs[i])
        if (srcs[i] != 0 && ((hz.memread_e0 && srcs[i] == hz.rd_e0) ||
                             (hz.memread_e1 && srcs[i] == hz.rd_e1)))
          luse = 1;
      dep = hz.regwrite_d0 && hz.rd_d0 != 0 &&
            (hz.rs1_d1 == hz.rd_d0 || hz.rs2_d1 == hz.rd_d0);
      conflict = hz.valid0_d && hz.valid1_d &&
                 (dep || (hz.mem_d0 && hz.mem_d1) || (hz.ctl_d0 && hz.ctl_d1));
      ld_dep = luse;
      if (hz.redirect_e) begin
        fd = 1; f0 = 1; f1 = 1; nsplit = 0; nfc = sat(m_fc);
      end else if (ld_dep) begin
        sf = 1; sd = 1; f0 = 1; f1 = 1; nlc = sat(m_lc);
      end else if (m_split) begin
        f0 = 1; nsplit = 0;
      end else if (conflict) begin
        sf = 1; sd = 1; f1 = 1; nsplit = 1; nsc = sat(m_sc);
      end
      exp_q.push_back({sf, sd, fd, f0, f1, m_split,
                       CNT_W'(m_sc), CNT_W'(m_lc), CNT_W'(m_fc)});
      m_split = nsplit; m_sc = nsc; m_lc = nlc; m_fc = nfc;
    end
    @(negedge clk);
  endtask

  // driver tasks
  task automatic idle();
    hz.valid0_d = 0; hz.valid1_d = 0;
    hz.rs1_d0 = 0; hz.rs2_d0 = 0; hz.rd_d0 = 0; hz.rs1_d1 = 0; hz.rs2_d1 = 0;
    hz.regwrite_d0 = 0; hz.mem_d0 = 0; hz.mem_d1 = 0; hz.ctl_d0 = 0; hz.ctl_d1 = 0;
    hz.memread_e0 = 0; hz.memread_e1 = 0; hz.rd_e0 = 0; hz.rd_e1 = 0;
    hz.redirect_e = 0;
  endtask

  task automatic pair(input logic [4:0] rd0, input logic [4:0] a0, input logic [4:0] b0,
                      input logic [4:0] a1, input logic [4:0] b1);
    idle();
    hz.valid0_d = 1; hz.valid1_d = 1; hz.regwrite_d0 = 1;
    hz.rd_d0 = rd0; hz.rs1_d0 = a0; hz.rs2_d0 = b0; hz.rs1_d1 = a1; hz.rs2_d1 = b1;
  endtask

  task automatic store_pair();
    pair(5'd0, 5'd1, 5'd2, 5'd10, 5'd11);
    hz.regwrite_d0 = 0; hz.mem_d0 = 1; hz.mem_d1 = 1;
  endtask

  task automatic rand_in();
    hz.valid0_d = ($urandom_range(0, 7) != 0);
    hz.valid1_d = ($urandom_range(0, 3) != 0);
    hz.rs1_d0 = 5'($urandom_range(0, 7)); hz.rs2_d0 = 5'($urandom_range(0, 7));
    hz.rd_d0  = 5'($urandom_range(0, 7));
    hz.rs1_d1 = 5'($urandom_range(0, 7)); hz.rs2_d1 = 5'($urandom_range(0, 7));
    hz.regwrite_d0 = 1'($urandom_range(0, 1));
    hz.mem_d0 = ($urandom_range(0, 2) == 0); hz.mem_d1 = ($urandom_range(0, 2) == 0);
    hz.ctl_d0 = ($urandom_range(0, 3) == 0); hz.ctl_d1 = ($urandom_range(0, 3) == 0);
    hz.memread_e0 = ($urandom_range(0, 3) == 0); hz.memread_e1 = ($urandom_range(0, 3) == 0);
    hz.rd_e0 = 5'($urandom_range(0, 7)); hz.rd_e1 = 5'($urandom_range(0, 7));
    hz.redirect_e = ($urandom_range(0, 7) == 0);
  endtask

  // monitor: outputs are combinational, so sample mid-low-phase after the driver settles
  initial begin
    logic [W-1:0] act, exp;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        act = {hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e0, hz.flush_e1,
               split_q, split_cnt, lu_cnt, flush_cnt};
        n_cmp++;
        if (act !== exp) begin
          n_bad++;
          $display("FAIL ctl_cnt t=%0t act sf/sd/fd/f0/f1/sq=%b cnt s/l/f=%0d/%0d/%0d exp sf/sd/fd/f0/f1/sq=%b cnt s/l/f=%0d/%0d/%0d",
                   $time, act[W-1 -: 6], act[3*CNT_W-1 -: CNT_W], act[2*CNT_W-1 -: CNT_W],
                   act[CNT_W-1:0], exp[W-1 -: 6], exp[3*CNT_W-1 -: CNT_W],
                   exp[2*CNT_W-1 -: CNT_W], exp[CNT_W-1:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    idle();
    @(negedge clk);
    tick();                                   // reset state
    rst_n = 1;
    tick();                                   // idle after reset

    pair(5'd5, 5'd1, 5'd2, 5'd6, 5'd7);       // independent pair
    tick();
    pair(5'd5, 5'd1, 5'd2, 5'd5, 5'd0);       // RAW inside pair -> split
    tick();
    tick();                                   // split second half

    pair(5'd12, 5'd9, 5'd0, 5'd3, 5'd4);      // load-use on EX pipe 1
    hz.memread_e1 = 1; hz.rd_e1 = 5'd9;
    tick();
    hz.memread_e1 = 0;
    tick();

    store_pair();                             // two memory ops -> split
    tick();
    hz.memread_e0 = 1; hz.rd_e0 = 5'd3; hz.rs1_d1 = 5'd3;
    tick();                                   // load-use held in SPLIT
    hz.memread_e0 = 0;
    tick();

    pair(5'd5, 5'd1, 5'd2, 5'd5, 5'd0);       // conflict with redirect
    hz.redirect_e = 1;
    tick();
    hz.redirect_e = 0;
    tick();                                   // now splits
    hz.redirect_e = 1;
    tick();                                   // redirect in SPLIT
    idle();
    tick();

    for (int i = 0; i < CMAX + 1; i++) begin  // drive split count into saturation
      store_pair();
      tick();
      idle();
      tick();
    end

    store_pair();                             // enter SPLIT, then reset asynchronously
    tick();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    idle();
    tick();

    for (int i = 0; i < 400; i++) begin
      rand_in();
      if ($urandom_range(0, 39) == 0) rst_n = 0;
      tick();
      rst_n = 1;
    end
    idle();
    tick();

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
